noc_router_xy: RTL

Five-port 2-D mesh router for the on-chip network, the parametrised successor of the 3-port linear router. Each input (East, West, North, South, Local) has a FIFO buffer. Flits are routed dimension-ordered, X first then Y, and each output port has its own independent round-robin arbiter. Each output has a registered stage that drains only while the downstream FIFO is not full. Tiles are instanced in an X×Y grid, with neighbouring ports wired back to back.

---
 rtl/noc_pkg.sv | 42 ++++
 rtl/noc_rr_arbiter.sv | 41 ++++
 rtl/noc_router_xy.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the XY mesh router: port indices, flit field offsets
// and the dimension-ordered route function.
package noc_pkg;

    localparam int NPORT  = 5;
    localparam int PIDX_W = 3;

    typedef logic [PIDX_W-1:0] port_idx_t;

    localparam port_idx_t P_E = 3'd0;
    localparam port_idx_t P_W = 3'd1;
    localparam port_idx_t P_N = 3'd2;
    localparam port_idx_t P_S = 3'd3;
    localparam port_idx_t P_L = 3'd4;

    function automatic int valid_bit();
        return 0;
    endfunction

    function automatic int x_lsb();
        return 1;
    endfunction

    function automatic int y_lsb(input int xw);
        return 1 + xw;
    endfunction

    function automatic int payload_lsb(input int xw, input int yw);
        return 1 + xw + yw;
    endfunction

    // X is resolved completely before Y, which keeps the mesh deadlock-free.
    function automatic port_idx_t route_xy(input int unsigned dx, input int unsigned dy,
                                           input int unsigned lx, input int unsigned ly);
        if (dx > lx)      return P_E;
        else if (dx < lx) return P_W;
        else if (dy > ly) return P_N;
        else if (dy < ly) return P_S;
        else              return P_L;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner and
// moves its pointer only when the grant is actually taken.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = NPORT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, sel;
    logic          found;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr_q) + k) % N);
            end
        end
        gnt = '0;
        if (en && found) gnt[sel] = 1'b1;
        ptr_d = (en && found) ? sel : ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= PW'(N - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/noc_router_xy.sv
// Five-port XY mesh router: FWFT input FIFOs, per-output round-robin
// arbitration and a registered output stage gated by downstream full.
module noc_router_xy
    import noc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int XW      = 2,
    parameter int YW      = 2,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORT-1:0]       writeIn,
    input  logic [NPORT*WIDTH-1:0] dataIn,
    output logic [NPORT-1:0]       full,
    output logic [NPORT-1:0]       almost_full,
    input  logic [NPORT-1:0]       readFull,
    output logic [NPORT*WIDTH-1:0] dataOut,
    output logic [NPORT-1:0]       writeOut
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NPORT*WIDTH-1:0]  head_flat;
    logic [NPORT-1:0]        head_valid;
    logic [NPORT*PIDX_W-1:0] dest_flat;
    logic [NPORT*NPORT-1:0]  req_flat;
    logic [NPORT*NPORT-1:0]  gnt_flat;
    logic [NPORT-1:0]        pop;

    for (genvar p = 0; p < NPORT; p++) begin : g_in
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    count_q, count_d;
        logic             full_q, full_d, afull_q, afull_d;
        logic             push;

        always_comb begin
            push     = writeIn[p] & dataIn[p*WIDTH + valid_bit()] & ~full_q;
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop[p]);
            count_d  = count_q + CW'(push) - CW'(pop[p]);
            full_d   = (count_d == CW'(DEPTH));
            afull_d  = (count_d >= CW'(DEPTH - 1));
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                full_q   <= 1'b0;
                afull_q  <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                full_q   <= full_d;
                afull_q  <= afull_d;
            end
        end

        // NOTE: the storage array is not reset; count_q alone decides which entries are live.
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= dataIn[p*WIDTH +: WIDTH];
        end

        assign head_flat[p*WIDTH +: WIDTH] = mem_q[rd_ptr_q];
        assign head_valid[p]               = (count_q != '0);
        assign full[p]                     = full_q;
        assign almost_full[p]              = afull_q;
    end

    always_comb begin
        dest_flat = '0;
        for (int i = 0; i < NPORT; i++) begin
            dest_flat[i*PIDX_W +: PIDX_W] = route_xy(
                int'(head_flat[i*WIDTH + x_lsb() +: XW]),
                int'(head_flat[i*WIDTH + y_lsb(XW) +: YW]),
                LOCAL_X, LOCAL_Y);
        end
    end

    always_comb begin
        req_flat = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                req_flat[o*NPORT + i] = head_valid[i] &&
                                        (dest_flat[i*PIDX_W +: PIDX_W] == PIDX_W'(o));
            end
        end
    end

    // Each input requests exactly one output, so OR-ing the grant columns never double-pops.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORT; o++) begin
            pop = pop | gnt_flat[o*NPORT +: NPORT];
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] out_data_q, out_data_d, sel_flit;
        logic [NPORT-1:0] gnt;
        logic             drain, out_free;

        assign drain    = out_valid_q & ~readFull[o];
        assign out_free = ~out_valid_q | drain;

        noc_rr_arbiter #(.N(NPORT)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_flat[o*NPORT +: NPORT]),
            .en    (out_free),
            .gnt   (gnt)
        );

        assign gnt_flat[o*NPORT +: NPORT] = gnt;

        always_comb begin
            sel_flit = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[i]) sel_flit = head_flat[i*WIDTH +: WIDTH];
            end
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            if (|gnt) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_flit;
            end else if (drain) begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign dataOut[o*WIDTH +: WIDTH] = out_data_q;
        assign writeOut[o]               = drain;
    end

endmodule
